// File: rtl/elevator_motion_controller.sv
// Elevator car motion controller.
// Steps the car one floor at a time toward the direction chosen by the
// upstream direction resolver. Opens and times the door at requested floors
// and sends one-hot clear pulses back to the request queue.
// current_floor and current_up_ndown are fed back to the resolver.
module elevator_motion_controller #(
    parameter int NUM_FLOORS  = 7,
    parameter int FLOOR_TICKS = 8,
    parameter int DOOR_TICKS  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] queue_status,
    input  logic       queue_empty,
    input  logic       next_up_ndown,
    input  logic       door_hold,
    output logic [2:0] current_floor,
    output logic       current_up_ndown,
    output logic       moving,
    output logic       door_open,
    output logic [6:0] floor_clear
);

    localparam int TRAV_W = (FLOOR_TICKS > 1) ? $clog2(FLOOR_TICKS) : 1;
    localparam int DOOR_W = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;

    localparam logic [TRAV_W-1:0] TRAV_LAST = TRAV_W'(FLOOR_TICKS - 1);
    localparam logic [DOOR_W-1:0] DOOR_LOAD = DOOR_W'(DOOR_TICKS - 1);
    localparam logic [2:0]        TOP_FLOOR = 3'(NUM_FLOORS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE      = 2'd1,
        ARRIVE    = 2'd2,
        DOOR_OPEN = 2'd3
    } state_t;

    state_t            state_reg;
    logic [TRAV_W-1:0] travel_cnt_reg;
    logic [DOOR_W-1:0] door_cnt_reg;

    // One-hot decode of the car position, used both to pick out the request
    // at the car and as the clear pulse pattern.
    logic [6:0] floor_is;

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_floor_dec
            assign floor_is[gi] = (current_floor == 3'(gi));
        end
    endgenerate

    // A request at the car that has not just been cleared by us. The queue
    // only drops the bit one cycle after our pulse, so the bit seen during
    // the pulse cycle is the request already being served.
    logic pending_here;
    assign pending_here = |(queue_status & ~floor_clear & floor_is);

    // True when stepping in the resolver's proposed direction stays in range.
    logic next_dir_ok;
    assign next_dir_ok = next_up_ndown ? (current_floor != TOP_FLOOR)
                                       : (current_floor != 3'd0);

    // Car state machine; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            current_floor    <= 3'd0;
            current_up_ndown <= 1'b1;
            moving           <= 1'b0;
            door_open        <= 1'b0;
            floor_clear      <= 7'd0;
            travel_cnt_reg   <= '0;
            door_cnt_reg     <= '0;
        end else begin
            floor_clear <= 7'd0;
            case (state_reg)
                IDLE: begin
                    if (pending_here) begin
                        state_reg    <= DOOR_OPEN;
                        door_open    <= 1'b1;
                        moving       <= 1'b0;
                        floor_clear  <= floor_is;
                        door_cnt_reg <= DOOR_LOAD;
                    end else if (!queue_empty) begin
                        current_up_ndown <= next_up_ndown;
                        if (next_dir_ok) begin
                            state_reg      <= MOVE;
                            moving         <= 1'b1;
                            travel_cnt_reg <= '0;
                        end
                    end
                end

                MOVE: begin
                    if (travel_cnt_reg == TRAV_LAST) begin
                        current_floor  <= current_up_ndown ? current_floor + 3'd1
                                                           : current_floor - 3'd1;
                        travel_cnt_reg <= '0;
                        state_reg      <= ARRIVE;
                    end else begin
                        travel_cnt_reg <= travel_cnt_reg + 1'b1;
                    end
                end

                ARRIVE: begin
                    if (pending_here) begin
                        state_reg    <= DOOR_OPEN;
                        door_open    <= 1'b1;
                        moving       <= 1'b0;
                        floor_clear  <= floor_is;
                        door_cnt_reg <= DOOR_LOAD;
                    end else if (queue_empty) begin
                        state_reg <= IDLE;
                        moving    <= 1'b0;
                    end else begin
                        current_up_ndown <= next_up_ndown;
                        if (next_dir_ok) begin
                            // The ARRIVE cycle is the first travel cycle of
                            // the next floor when passing through, so a run
                            // of N floors takes N*FLOOR_TICKS cycles.
                            state_reg      <= MOVE;
                            travel_cnt_reg <= TRAV_W'(1);
                        end else begin
                            state_reg <= IDLE;
                            moving    <= 1'b0;
                        end
                    end
                end

                DOOR_OPEN: begin
                    if (pending_here) begin
                        floor_clear  <= floor_is;
                        door_cnt_reg <= DOOR_LOAD;
                    end else if (door_hold) begin
                        door_cnt_reg <= DOOR_LOAD;
                    end else if (door_cnt_reg == '0) begin
                        state_reg <= IDLE;
                        door_open <= 1'b0;
                    end else begin
                        door_cnt_reg <= door_cnt_reg - 1'b1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    moving    <= 1'b0;
                    door_open <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_motion_controller.sv
// Directed bench for elevator_motion_controller with a request-queue model
// and a direction-resolver model attached around the car controller.
module tb_elevator_motion_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] queue;
    logic       queue_empty;
    logic       next_up_ndown;
    logic       door_hold;
    logic [2:0] current_floor;
    logic       current_up_ndown;
    logic       moving;
    logic       door_open;
    logic [6:0] floor_clear;

    logic [6:0] set_req;
    logic       force_mode;
    logic       forced_empty;
    logic       forced_next;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    elevator_motion_controller #(
        .NUM_FLOORS (7),
        .FLOOR_TICKS(8),
        .DOOR_TICKS (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .queue_status    (queue),
        .queue_empty     (queue_empty),
        .next_up_ndown   (next_up_ndown),
        .door_hold       (door_hold),
        .current_floor   (current_floor),
        .current_up_ndown(current_up_ndown),
        .moving          (moving),
        .door_open       (door_open),
        .floor_clear     (floor_clear)
    );

    // Request queue: set by stimulus, cleared by the controller's pulses.
    always @(posedge clk) begin
        if (!rst_n) queue <= 7'd0;
        else        queue <= (queue & ~floor_clear) | set_req;
    end

    // Direction resolver: keep going while requests lie ahead, else reverse.
    always_comb begin
        logic above;
        logic below;
        logic res_next;
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i > int'(current_floor)) above = above | queue[i];
            if (i < int'(current_floor)) below = below | queue[i];
        end
        if (current_up_ndown) res_next = above ? 1'b1 : (below ? 1'b0 : 1'b1);
        else                  res_next = below ? 1'b0 : (above ? 1'b1 : 1'b0);
        queue_empty   = force_mode ? forced_empty : !(above || below);
        next_up_ndown = force_mode ? forced_next  : res_next;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse one request into the queue; the queue holds it after this tick.
    task automatic request(input int floor);
        set_req = 7'(1 << floor);
        tick();
        set_req = 7'd0;
    endtask

    // Wait (bounded) until door_open reaches the wanted level.
    task automatic wait_door(input logic want, input int limit, output int n);
        n = 0;
        while (door_open !== want && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int n_open;
        int n_clear;
        rst_n        = 1'b0;
        set_req      = 7'd0;
        door_hold    = 1'b0;
        force_mode   = 1'b0;
        forced_empty = 1'b1;
        forced_next  = 1'b1;

        // Reset held three cycles
        repeat (3) tick();
        check("rst_floor", 32'(current_floor), 0);
        check("rst_dir", 32'(current_up_ndown), 1);
        check("rst_moving", 32'(moving), 0);
        check("rst_door", 32'(door_open), 0);
        check("rst_clear", 32'(floor_clear), 0);
        rst_n = 1'b1;
        repeat (5) tick();
        check("idle_floor", 32'(current_floor), 0);
        check("idle_moving", 32'(moving), 0);
        check("idle_door", 32'(door_open), 0);
        check("idle_clear", 32'(floor_clear), 0);

        // Request at the current floor opens the door without moving
        request(0);
        check("cf_wait_door", 32'(door_open), 0);
        tick();
        check("cf_door", 32'(door_open), 1);
        check("cf_clear", 32'(floor_clear), 32'h01);
        check("cf_moving", 32'(moving), 0);
        check("cf_floor", 32'(current_floor), 0);
        tick();
        check("cf_clear_once", 32'(floor_clear), 0);

        // Door hold for 40 cycles, then 16 more cycles of open door
        door_hold = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            check("hold_open", 32'(door_open), 1);
        end
        door_hold = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("release_open", 32'(door_open), 1);
        end
        tick();
        check("release_closed", 32'(door_open), 0);

        // Single trip from 0 to 3: floor 3 exactly 24 cycles after MOVE entry
        request(3);
        tick();
        check("trip_moving", 32'(moving), 1);
        check("trip_dir", 32'(current_up_ndown), 1);
        repeat (7) tick();
        check("trip_f0_m7", 32'(current_floor), 0);
        tick();
        check("trip_f1_m8", 32'(current_floor), 1);
        check("trip_arrive_moving", 32'(moving), 1);
        repeat (15) tick();
        check("trip_f2_m23", 32'(current_floor), 2);
        tick();
        check("trip_f3_m24", 32'(current_floor), 3);
        tick();
        check("trip_door", 32'(door_open), 1);
        check("trip_clear", 32'(floor_clear), 32'h08);
        check("trip_stopped", 32'(moving), 0);
        n_open  = 1;
        n_clear = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (door_open)          n_open++;
            if (floor_clear != 7'd0) n_clear++;
        end
        check("trip_door_cycles", 32'(n_open), 16);
        check("trip_extra_clears", 32'(n_clear), 0);
        check("trip_rest_floor", 32'(current_floor), 3);

        // 3 -> 6, then 6 -> 1 (direction change)
        request(6);
        wait_door(1'b1, 200, n);
        check("up6_latency", 32'(n), 26);
        check("up6_floor", 32'(current_floor), 6);
        check("up6_clear", 32'(floor_clear), 32'h40);
        wait_door(1'b0, 200, n);
        check("up6_closed", 32'(door_open), 0);
        request(1);
        wait_door(1'b1, 200, n);
        check("down1_latency", 32'(n), 42);
        check("down1_floor", 32'(current_floor), 1);
        check("down1_clear", 32'(floor_clear), 32'h02);
        check("down1_dir", 32'(current_up_ndown), 0);
        wait_door(1'b0, 200, n);
        repeat (10) tick();
        check("down1_rest", 32'(current_floor), 1);
        check("down1_rest_moving", 32'(moving), 0);

        // Back to 6, then force "go up" at the top floor
        request(6);
        wait_door(1'b1, 200, n);
        check("top_floor", 32'(current_floor), 6);
        wait_door(1'b0, 200, n);
        force_mode   = 1'b1;
        forced_empty = 1'b0;
        forced_next  = 1'b1;
        repeat (12) tick();
        check("top_guard_floor", 32'(current_floor), 6);
        check("top_guard_moving", 32'(moving), 0);
        force_mode = 1'b0;

        // Reset in the middle of travel, travel counter at 4
        request(2);
        tick();
        check("mid_moving", 32'(moving), 1);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst_floor", 32'(current_floor), 0);
        check("mid_rst_moving", 32'(moving), 0);
        check("mid_rst_door", 32'(door_open), 0);
        check("mid_rst_clear", 32'(floor_clear), 0);
        check("mid_rst_dir", 32'(current_up_ndown), 1);
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_floor", 32'(current_floor), 0);
        check("post_rst_clear", 32'(floor_clear), 0);

        // Force "go down" at floor 0
        force_mode   = 1'b1;
        forced_empty = 1'b0;
        forced_next  = 1'b0;
        repeat (10) tick();
        check("bot_guard_floor", 32'(current_floor), 0);
        check("bot_guard_moving", 32'(moving), 0);
        force_mode = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/elevator_motion_controller.md
Name: elevator_motion_controller

Overview:
Sequential car controller that sits directly downstream of the elevator direction resolver. It consumes the resolver's `next_up_ndown` and `queue_empty`, and the request queue. It owns `current_floor` and `current_up_ndown`, which it feeds back to the resolver. It steps the car floor by floor, opens and times the door at requested floors, and issues one-hot clear pulses back to the request queue.

Parameters:
- NUM_FLOORS, 7, number of floors; fixed to 7 to match the 7-bit queue and 3-bit floor encoding.
- FLOOR_TICKS, 8, clock cycles of travel per floor step (must be ≥ 2).
- DOOR_TICKS, 16, clock cycles the door stays open with no hold (must be ≥ 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- queue_status  input  7  pending floor requests; bit i = floor i.
- queue_empty  input  1  from resolver; no request above or below the car.
- next_up_ndown  input  1  from resolver; 1 = up, 0 = down.
- door_hold  input  1  door-open button; level sensitive.
- current_floor  output  3  registered car floor, 0..6.
- current_up_ndown  output  1  registered travel direction, fed to resolver.
- moving  output  1  high while in MOVE or ARRIVE.
- door_open  output  1  high while in DOOR_OPEN.
- floor_clear  output  7  one-cycle one-hot pulse clearing the served request.

Behaviour:
- Reset: one clock and one synchronous active-low reset, `rst_n`. While `rst_n` = 0 at a clk edge, the block enters the following state regardless of current state, including mid-travel and door-open:
  - state = IDLE, current_floor = 0, current_up_ndown = 1;
  - moving = 0, door_open = 0, floor_clear = 0;
  - travel and door counters = 0.
- All outputs are registered. floor_clear is 0 except for single-cycle pulses.
- States: IDLE, MOVE, ARRIVE, DOOR_OPEN.
- IDLE, evaluated in priority order each cycle:
  - queue_status[current_floor] = 1 → DOOR_OPEN; floor_clear = 1 << current_floor for one cycle; door counter loaded.
  - Else queue_empty = 0 → latch current_up_ndown <= next_up_ndown; travel counter = 0; go to MOVE.
  - Else stay in IDLE.
- IDLE direction guard: if the latched direction would leave 0..6 (floor 6 going up, or floor 0 going down), stay in IDLE. The car never moves out of range.
- MOVE:
  - Travel counter increments each cycle.
  - When it reaches FLOOR_TICKS-1: current_floor ±1 per current_up_ndown, counter clears, go to ARRIVE.
  - Floor step latency is exactly FLOOR_TICKS cycles from MOVE entry to the current_floor update.
  - Direction is not re-read during MOVE.
- ARRIVE: one cycle; the resolver sees the new floor here.
  - queue_status[current_floor] = 1 → DOOR_OPEN with floor_clear pulse.
  - Else queue_empty = 1 → IDLE.
  - Else latch next_up_ndown; apply the direction guard. If in range → MOVE; otherwise → IDLE.
- DOOR_OPEN:
  - Door counter counts DOOR_TICKS cycles; at expiry → IDLE.
  - door_hold = 1 reloads the counter every cycle; the door cannot close while hold is asserted.
  - A new request on current_floor while the door is open produces another floor_clear pulse and reloads the counter.
- Simultaneous events:
  - A request at the current floor beats departure.
  - Reset beats everything.
  - A clear pulse and a same-cycle re-request of the same floor are resolved by the queue block (set wins), not here.
- Arithmetic: counters are sized with $clog2 of the max parameter. Floor ±1 is 3-bit with no wrap, guaranteed by the guard.

Test Plan:
- Reset idle: hold rst_n low 3 cycles, then release with queue 0 → floor 0, dir 1, moving 0, door_open 0, floor_clear 0 indefinitely.
- Single trip: set queue_status = 7'b000_1000 with the resolver model attached → up, 3×8 travel cycles, floor 3 at cycle 24 after MOVE entry, floor_clear = 7'b000_1000 once, door_open for 16 cycles, then IDLE.
- Current-floor request: car at 0 idle, queue = 7'b000_0001 → next cycle door_open = 1 and floor_clear = 7'b000_0001; no movement.
- Door hold: during DOOR_OPEN assert door_hold for 40 cycles → door_open stays 1 throughout, closes exactly 16 cycles after release.
- Direction change and bounds: car at 6, queue = 7'b000_0010 → moves down to 1 and stops there. Force next_up_ndown = 1 at floor 6 with queue_empty = 0 → car stays at 6.
- Reset mid-travel: assert rst_n = 0 during MOVE at counter 4 → next edge floor 0, moving 0; no floor_clear pulse.
